dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single data RAM between the pipelined core's data port (port A) and a second requester (port B: program/data loader or debug access). It grants at most one access per cycle and drives the RAM strobes, address and write data from the winner. It returns read data to the correct requester one cycle later. A bounded-priority policy keeps port B from starving while the core keeps port A busy.

## Interface
Parameters:
- ADDR_SIZE, 10, RAM word-address width
- DATA_SIZE, 32, data width
- MAX_HOLD, 4, max consecutive contended grants to the priority port before priority flips (≥1)

Ports:
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  synchronous reset, active-high
- a_req  in  1  port A access request
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  ADDR_SIZE  port A address
- a_wdata  in  DATA_SIZE  port A write data
- a_gnt  out  1  port A granted this cycle
- a_rvalid  out  1  port A read data valid
- a_rdata  out  DATA_SIZE  port A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B
- daddr  out  ADDR_SIZE  to RAM address
- MemWrite  out  1  to RAM write strobe
- MemRead  out  1  to RAM read strobe
- ddata_w  out  DATA_SIZE  to RAM write data
- ddata_r  in  DATA_SIZE  from RAM, valid the cycle after MemRead
- stall_cnt  out  16  saturating count of cycles in which some request was denied

## Operation
- Priority register `prio` is either PRIO_A or PRIO_B. The hold counter `hold` runs from 0 to MAX_HOLD-1.
- Grant is combinational in the request cycle:
  - Only one port requests: that port is granted.
  - Both ports request: the `prio` port is granted.
  - Neither requests: no grant.
- A denied requester holds req, we, addr and wdata stable until it is granted. The arbiter does not queue requests.
- RAM drive:
  - With a grant: daddr and ddata_w come from the winner; MemWrite = winner_we; MemRead = ~winner_we.
  - With no grant: MemRead = MemWrite = 0. daddr and ddata_w hold the port A values.
- Priority update at each clock edge:
  - Contended cycle (both request): if hold == MAX_HOLD-1, flip `prio` and clear hold; otherwise increment hold.
  - Uncontended cycle: clear hold; `prio` is unchanged.
- Read return: a granted read on port X sets X_rvalid for exactly the next cycle, with X_rdata = ddata_r. The other port's rvalid stays 0.
- rdata may carry any value when rvalid = 0.
- Writes complete at grant and produce no rvalid.
- stall_cnt increments on each cycle with a denied request and saturates at 16'hFFFF.

## Timing
- Reset state: prio = PRIO_A, hold = 0, a_rvalid = b_rvalid = 0, stall_cnt = 0.
- While RESET = 1, a_gnt, b_gnt, MemRead and MemWrite are forced to 0 regardless of requests.
- Grant latency is 0 cycles; read data latency is 1 cycle after grant. Sustained throughput is 1 access per cycle with no bubbles between grants or port switches.
- Back-to-back reads on alternating ports: each rvalid follows its own grant by one cycle.
- RESET asserted in the cycle after a granted read: the rvalid for that read is suppressed and the response is dropped.
- If MAX_HOLD = 1, priority alternates on every contended cycle (strict round-robin under contention).
- Request and grant in the same cycle as the priority flip: the grant uses the pre-edge `prio`. The flip affects the next cycle only.

## Test plan
- Reset, then A-only read of addr 5 (RAM[5] = 32'hDEADBEEF):
  - a_gnt = 1 and MemRead = 1 in cycle 0.
  - a_rvalid = 1 and a_rdata = 32'hDEADBEEF in cycle 1.
  - b_rvalid = 0, stall_cnt = 0.
- B-only write of 32'h12345678 to addr 9, then B read of addr 9:
  - MemWrite = 1 for one cycle, b_gnt = 1 each time.
  - b_rdata = 32'h12345678 one cycle after the read grant.
- Both ports request continuously, MAX_HOLD = 4:
  - Grant pattern from reset is A,A,A,A,B,B,B,B,A…
  - stall_cnt = 8 after 8 cycles.
- Contention for 2 cycles, idle 1 cycle, contention again:
  - Grants A,A,(none),A,A,A,A,B…, because hold clears on the uncontended cycle.
- Alternating reads A@1, B@2, A@3 with both requests staggered:
  - Each rvalid appears only on the owning port, one cycle after its grant, with the matching RAM data.
- A read granted at cycle N, RESET = 1 at cycle N+1:
  - a_rvalid = 0 at N+1; gnt, MemRead and MemWrite = 0 while reset.
  - After release, prio = PRIO_A and stall_cnt = 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data RAM between the core data port (A) and a
// loader/debug port (B). One access per cycle, combinational grant, read
// data steered back to the winning port one cycle later. Under sustained
// contention the priority flips after MAX_HOLD consecutive contended grants.
module dmem_arbiter #(
  parameter int ADDR_SIZE = 10,
  parameter int DATA_SIZE = 32,
  parameter int MAX_HOLD  = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [DATA_SIZE-1:0] a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [DATA_SIZE-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [DATA_SIZE-1:0] b_wdata,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [DATA_SIZE-1:0] b_rdata,
  output logic [ADDR_SIZE-1:0] daddr,
  output logic                 MemWrite,
  output logic                 MemRead,
  output logic [DATA_SIZE-1:0] ddata_w,
  input  logic [DATA_SIZE-1:0] ddata_r,
  output logic [15:0]          stall_cnt
);

  // hold needs at least one bit even when MAX_HOLD is 1
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  prio_t             prio_r;
  prio_t             prio_nxt_s;
  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] hold_nxt_s;
  logic              a_win_s;
  logic              b_win_s;
  logic              denied_s;
  logic              a_rv_r;
  logic              b_rv_r;
  logic [15:0]       stall_r;

  // Grant decision: single requester wins, contention goes to prio, nothing during reset
  always_comb begin
    a_win_s = 1'b0;
    b_win_s = 1'b0;
    if (RESET) begin
      a_win_s = 1'b0;
      b_win_s = 1'b0;
    end else if (a_req && b_req) begin
      if (prio_r == PRIO_A) begin
        a_win_s = 1'b1;
      end else begin
        b_win_s = 1'b1;
      end
    end else if (a_req) begin
      a_win_s = 1'b1;
    end else if (b_req) begin
      b_win_s = 1'b1;
    end else begin
      a_win_s = 1'b0;
      b_win_s = 1'b0;
    end
  end

  assign a_gnt    = a_win_s;
  assign b_gnt    = b_win_s;
  assign denied_s = (a_req & ~a_win_s) | (b_req & ~b_win_s);

  // RAM drive: winner's address/data/strobes; idle cycles park on port A values
  always_comb begin
    daddr    = a_addr;
    ddata_w  = a_wdata;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    if (b_win_s) begin
      daddr    = b_addr;
      ddata_w  = b_wdata;
      MemWrite = b_we;
      MemRead  = ~b_we;
    end else if (a_win_s) begin
      MemWrite = a_we;
      MemRead  = ~a_we;
    end else begin
      MemWrite = 1'b0;
      MemRead  = 1'b0;
    end
  end

  // Bounded-priority update: count contended cycles, flip after MAX_HOLD of them
  always_comb begin
    prio_nxt_s = prio_r;
    hold_nxt_s = hold_r;
    if (a_req && b_req) begin
      if (hold_r == HOLD_LAST) begin
        prio_nxt_s = (prio_r == PRIO_A) ? PRIO_B : PRIO_A;
        hold_nxt_s = {HOLD_W{1'b0}};
      end else begin
        hold_nxt_s = hold_r + HOLD_W'(1);
      end
    end else begin
      hold_nxt_s = {HOLD_W{1'b0}};
    end
  end

  // State register: priority, hold counter, read-return flags and stall counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prio_r  <= PRIO_A;
      hold_r  <= {HOLD_W{1'b0}};
      a_rv_r  <= 1'b0;
      b_rv_r  <= 1'b0;
      stall_r <= 16'h0000;
    end else begin
      prio_r <= prio_nxt_s;
      hold_r <= hold_nxt_s;
      a_rv_r <= a_win_s & ~a_we;
      b_rv_r <= b_win_s & ~b_we;
      if (denied_s && (stall_r != 16'hFFFF)) begin
        stall_r <= stall_r + 16'h0001;
      end else begin
        stall_r <= stall_r;
      end
    end
  end

  // A response pending when reset arrives is dropped, so mask the flags with RESET
  assign a_rvalid  = a_rv_r & ~RESET;
  assign b_rvalid  = b_rv_r & ~RESET;
  assign a_rdata   = ddata_r;
  assign b_rdata   = ddata_r;
  assign stall_cnt = stall_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors with a queue scoreboard for read data.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [9:0]  a_addr, b_addr, daddr;
  logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata, ddata_w, ddata_r;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, mem_write, mem_read;
  logic [15:0] stall_cnt;

  logic [31:0] mem [0:1023];
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int total = 0;
  int bad = 0;

  dmem_arbiter #(.ADDR_SIZE(10), .DATA_SIZE(32), .MAX_HOLD(4)) dut (
    .CLK(clk), .RESET(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .daddr(daddr), .MemWrite(mem_write), .MemRead(mem_read),
    .ddata_w(ddata_w), .ddata_r(ddata_r), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // RAM model: preload known words during reset, one-cycle read latency
  always @(posedge clk) begin
    if (rst) begin
      mem[1] <= 32'h11111111;
      mem[2] <= 32'h22222222;
      mem[3] <= 32'h33333333;
      mem[5] <= 32'hDEADBEEF;
    end else begin
      if (mem_write) mem[daddr] <= ddata_w;
    end
    if (mem_read) ddata_r <= mem[daddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rvalid pops the owning port's queue and compares data
  always @(negedge clk) begin
    if (a_rvalid === 1'b1) begin
      if (qa.size() == 0) chk("a_spurious_rvalid", 32'(a_rvalid), 32'd0);
      else chk("a_rdata", a_rdata, qa.pop_front());
    end
    if (b_rvalid === 1'b1) begin
      if (qb.size() == 0) chk("b_spurious_rvalid", 32'(b_rvalid), 32'd0);
      else chk("b_rdata", b_rdata, qb.pop_front());
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [9:0] aad, input logic [31:0] ad,
                       input logic br, input logic bw, input logic [9:0] bad_, input logic [31:0] bd);
    a_req = ar; a_we = aw; a_addr = aad; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = bad_; b_wdata = bd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    idle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    string pat;
    string pat2;
    logic  ea;
    logic  eb;

    // reset with both ports requesting: nothing granted, state cleared
    rst = 1'b1;
    drive(1'b1, 1'b0, 10'd5, 32'd0, 1'b1, 1'b0, 10'd2, 32'd0);
    next_cycle();
    #3;
    chk("rst_a_gnt", 32'(a_gnt), 32'd0);
    chk("rst_b_gnt", 32'(b_gnt), 32'd0);
    chk("rst_memread", 32'(mem_read), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    next_cycle();

    // A-only read of addr 5
    rst = 1'b0;
    drive(1'b1, 1'b0, 10'd5, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    #3;
    chk("t1_a_gnt", 32'(a_gnt), 32'd1);
    chk("t1_memread", 32'(mem_read), 32'd1);
    chk("t1_daddr", 32'(daddr), 32'd5);
    qa.push_back(32'hDEADBEEF);
    next_cycle();
    idle();
    #3;
    chk("t1_a_rvalid", 32'(a_rvalid), 32'd1);
    chk("t1_b_rvalid", 32'(b_rvalid), 32'd0);
    chk("t1_stall", 32'(stall_cnt), 32'd0);
    next_cycle();

    // B-only write then read of addr 9
    drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b1, 10'd9, 32'h12345678);
    #3;
    chk("t2_b_gnt_w", 32'(b_gnt), 32'd1);
    chk("t2_memwrite", 32'(mem_write), 32'd1);
    chk("t2_memread_w", 32'(mem_read), 32'd0);
    chk("t2_daddr", 32'(daddr), 32'd9);
    chk("t2_wdata", ddata_w, 32'h12345678);
    next_cycle();
    drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 10'd9, 32'd0);
    #3;
    chk("t2_b_gnt_r", 32'(b_gnt), 32'd1);
    chk("t2_memwrite_r", 32'(mem_write), 32'd0);
    qb.push_back(32'h12345678);
    next_cycle();
    idle();
    #3;
    chk("t2_b_rvalid", 32'(b_rvalid), 32'd1);
    chk("t2_a_rvalid", 32'(a_rvalid), 32'd0);
    next_cycle();

    // continuous contention from reset: A x4, B x4, A
    reset_pulse();
    pat = "AAAABBBBA";
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 10'd100, 32'(i), 1'b1, 1'b1, 10'd101, 32'(i));
      #3;
      ea = (pat[i] == "A");
      eb = (pat[i] == "B");
      chk("t3_a_gnt", 32'(a_gnt), 32'(ea));
      chk("t3_b_gnt", 32'(b_gnt), 32'(eb));
      if (i == 8) chk("t3_stall8", 32'(stall_cnt), 32'd8);
      next_cycle();
    end

    // contention 2, idle 1, contention again: hold clears on the idle cycle
    reset_pulse();
    pat2 = "AA-AAAAB";
    for (int i = 0; i < 8; i++) begin
      if (i == 2) drive(1'b0, 1'b1, 10'd7, 32'd0, 1'b0, 1'b1, 10'd8, 32'd0);
      else drive(1'b1, 1'b1, 10'd100, 32'(i), 1'b1, 1'b1, 10'd101, 32'(i));
      #3;
      ea = (pat2[i] == "A");
      eb = (pat2[i] == "B");
      chk("t4_a_gnt", 32'(a_gnt), 32'(ea));
      chk("t4_b_gnt", 32'(b_gnt), 32'(eb));
      if (i == 2) begin
        chk("t4_idle_memwrite", 32'(mem_write), 32'd0);
        chk("t4_idle_daddr", 32'(daddr), 32'd7);
      end
      next_cycle();
    end

    // alternating reads A@1, B@2, A@3
    reset_pulse();
    drive(1'b1, 1'b0, 10'd1, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    #3;
    chk("t5_a_gnt0", 32'(a_gnt), 32'd1);
    qa.push_back(32'h11111111);
    next_cycle();
    drive(1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 10'd2, 32'd0);
    #3;
    chk("t5_b_gnt1", 32'(b_gnt), 32'd1);
    chk("t5_a_rv1", 32'(a_rvalid), 32'd1);
    chk("t5_b_rv1", 32'(b_rvalid), 32'd0);
    qb.push_back(32'h22222222);
    next_cycle();
    drive(1'b1, 1'b0, 10'd3, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    #3;
    chk("t5_a_gnt2", 32'(a_gnt), 32'd1);
    chk("t5_b_rv2", 32'(b_rvalid), 32'd1);
    chk("t5_a_rv2", 32'(a_rvalid), 32'd0);
    qa.push_back(32'h33333333);
    next_cycle();
    idle();
    #3;
    chk("t5_a_rv3", 32'(a_rvalid), 32'd1);
    chk("t5_b_rv3", 32'(b_rvalid), 32'd0);
    next_cycle();

    // read followed by reset: response dropped, state restored
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 10'd100, 32'(i), 1'b1, 1'b1, 10'd101, 32'(i));
      next_cycle();
    end
    drive(1'b1, 1'b0, 10'd5, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    #3;
    chk("t6_a_gnt", 32'(a_gnt), 32'd1);
    next_cycle();
    rst = 1'b1;
    drive(1'b1, 1'b0, 10'd5, 32'd0, 1'b1, 1'b1, 10'd6, 32'd0);
    #3;
    chk("t6_a_rvalid_drop", 32'(a_rvalid), 32'd0);
    chk("t6_a_gnt_rst", 32'(a_gnt), 32'd0);
    chk("t6_b_gnt_rst", 32'(b_gnt), 32'd0);
    chk("t6_memread_rst", 32'(mem_read), 32'd0);
    chk("t6_memwrite_rst", 32'(mem_write), 32'd0);
    next_cycle();
    rst = 1'b0;
    drive(1'b1, 1'b1, 10'd100, 32'd0, 1'b1, 1'b1, 10'd101, 32'd0);
    #3;
    chk("t6_stall_cleared", 32'(stall_cnt), 32'd0);
    chk("t6_prio_a", 32'(a_gnt), 32'd1);
    chk("t6_prio_b", 32'(b_gnt), 32'd0);
    next_cycle();
    idle();
    next_cycle();
    next_cycle();

    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
